// File: rtl/sprite_layer_renderer.sv
// Sprite layer: maps the scan position to a sprite-ROM address with a runtime integer scale,
// then composites the palette colour over a background stream. Position, scale and enable are
// shadowed once per frame. Address generation uses counters only; three-stage pipeline.
module sprite_layer_renderer #(
   parameter int unsigned SCREEN_W        = 640,
   parameter int unsigned SCREEN_H        = 480,
   parameter int unsigned SPR_W           = 128,
   parameter int unsigned SPR_H           = 128,
   parameter int unsigned IDX_W           = 4,
   parameter int unsigned COLOR_W         = 4,
   parameter int unsigned MAX_SCALE       = 4,
   parameter int unsigned TRANSPARENT_IDX = 0,
   parameter int unsigned ADDR_W          = $clog2(SPR_W * SPR_H)
) (
   input  logic                           vga_clk,
   input  logic                           reset,
   input  logic [9:0]                     DrawX,
   input  logic [9:0]                     DrawY,
   input  logic                           blank,
   input  logic [9:0]                     pos_x,
   input  logic [9:0]                     pos_y,
   input  logic [$clog2(MAX_SCALE+1)-1:0] scale,
   input  logic                           sprite_en,
   input  logic [COLOR_W-1:0]             bg_red,
   input  logic [COLOR_W-1:0]             bg_green,
   input  logic [COLOR_W-1:0]             bg_blue,
   output logic [ADDR_W-1:0]              rom_addr,
   input  logic [IDX_W-1:0]               rom_q,
   output logic [IDX_W-1:0]               pal_index,
   input  logic [COLOR_W-1:0]             pal_red,
   input  logic [COLOR_W-1:0]             pal_green,
   input  logic [COLOR_W-1:0]             pal_blue,
   output logic [COLOR_W-1:0]             red,
   output logic [COLOR_W-1:0]             green,
   output logic [COLOR_W-1:0]             blue,
   output logic                           sprite_hit
);

   localparam int unsigned SC_W = $clog2(MAX_SCALE + 1);
   localparam int unsigned CX_W = $clog2(SPR_W + 1);
   localparam int unsigned CY_W = $clog2(SPR_H + 1);
   localparam int unsigned RB_W = $clog2(SPR_W * SPR_H + 1);

   localparam logic [9:0]       SCR_W     = 10'(SCREEN_W);
   localparam logic [9:0]       LOAD_Y    = 10'(SCREEN_H);
   localparam logic [SC_W-1:0]  SCALE_MAX = SC_W'(MAX_SCALE);
   localparam logic [CX_W-1:0]  COL_END   = CX_W'(SPR_W);
   localparam logic [CY_W-1:0]  ROW_END   = CY_W'(SPR_H);
   localparam logic [RB_W-1:0]  ROW_STEP  = RB_W'(SPR_W);
   localparam logic [IDX_W-1:0] CLEAR_IDX = IDX_W'(TRANSPARENT_IDX);

   // Per-frame shadow state
   logic            load;
   logic [9:0]      pos_x_s_q, pos_x_s_d;
   logic [9:0]      pos_y_s_q, pos_y_s_d;
   logic [SC_W-1:0] scale_s_q, scale_s_d;
   logic [SC_W-1:0] scale_clamp;
   logic [SC_W-1:0] scale_m1;
   logic            en_s_q, en_s_d;

   // Column counters (texel column and sub-pixel within a texel)
   logic [CX_W-1:0] col_q, col_d, col_cur;
   logic [SC_W-1:0] csub_q, csub_d, csub_cur;

   // Row counters; rbase tracks row * SPR_W so no multiplier is needed
   logic [9:0]      line_q, line_d;
   logic [CY_W-1:0] row_q, row_d, row_cur;
   logic [SC_W-1:0] rsub_q, rsub_d, rsub_cur;
   logic [RB_W-1:0] rbase_q, rbase_d, rbase_cur;

   logic              inside_c;
   logic [ADDR_W-1:0] addr_c;

   // Pipeline stages
   logic [ADDR_W-1:0]  rom_addr_q;
   logic               in1_q, blank1_q;
   logic [COLOR_W-1:0] bg_r1_q, bg_g1_q, bg_b1_q;
   logic               in2_q, blank2_q;
   logic [COLOR_W-1:0] bg_r2_q, bg_g2_q, bg_b2_q;
   logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic               hit_q, hit_d;

   assign load     = (DrawY == LOAD_Y) && (DrawX == 10'd0);
   assign scale_m1 = scale_s_q - SC_W'(1);

   // Clamp the requested scale into 1..MAX_SCALE
   always_comb begin
      scale_clamp = scale;
      if (scale == '0) begin
         scale_clamp = SC_W'(1);
      end else if (scale > SCALE_MAX) begin
         scale_clamp = SCALE_MAX;
      end
   end

   // Shadow registers capture the requested settings once per frame, in vertical blanking
   always_comb begin
      pos_x_s_d = pos_x_s_q;
      pos_y_s_d = pos_y_s_q;
      scale_s_d = scale_s_q;
      en_s_d    = en_s_q;
      if (load) begin
         pos_x_s_d = pos_x;
         pos_y_s_d = pos_y;
         scale_s_d = scale_clamp;
         en_s_d    = sprite_en;
      end
   end

   // Shadow register state
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         pos_x_s_q <= '0;
         pos_y_s_q <= '0;
         scale_s_q <= SC_W'(1);
         en_s_q    <= 1'b0;
      end else begin
         pos_x_s_q <= pos_x_s_d;
         pos_y_s_q <= pos_y_s_d;
         scale_s_q <= scale_s_d;
         en_s_q    <= en_s_d;
      end
   end

   // Column counters: value for this pixel, then step to the next pixel of the line
   always_comb begin
      col_cur  = col_q;
      csub_cur = csub_q;
      if (DrawX == pos_x_s_q) begin
         col_cur  = '0;
         csub_cur = '0;
      end
      col_d  = col_cur;
      csub_d = csub_cur + SC_W'(1);
      // >= rather than == so stale sub-counts after a scale change still wrap
      if (csub_cur >= scale_m1) begin
         csub_d = '0;
         if (col_cur != COL_END) begin
            col_d = col_cur + CX_W'(1);
         end
      end
   end

   // Row counters advance once, on the first pixel of each new line
   always_comb begin
      line_d    = DrawY;
      row_cur   = row_q;
      rsub_cur  = rsub_q;
      rbase_cur = rbase_q;
      if (DrawY != line_q) begin
         if (DrawY == pos_y_s_q) begin
            row_cur   = '0;
            rsub_cur  = '0;
            rbase_cur = '0;
         end else if (rsub_q >= scale_m1) begin
            rsub_cur = '0;
            if (row_q != ROW_END) begin
               row_cur   = row_q + CY_W'(1);
               rbase_cur = rbase_q + ROW_STEP;
            end
         end else begin
            rsub_cur = rsub_q + SC_W'(1);
         end
      end
      row_d   = row_cur;
      rsub_d  = rsub_cur;
      rbase_d = rbase_cur;
   end

   // Counter state
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         col_q   <= '0;
         csub_q  <= '0;
         line_q  <= '0;
         row_q   <= '0;
         rsub_q  <= '0;
         rbase_q <= '0;
      end else begin
         col_q   <= col_d;
         csub_q  <= csub_d;
         line_q  <= line_d;
         row_q   <= row_d;
         rsub_q  <= rsub_d;
         rbase_q <= rbase_d;
      end
   end

   // Sprite box test and texel address; the >= compares give the dx, dy >= 0 half of the box
   always_comb begin
      inside_c = en_s_q && (DrawX >= pos_x_s_q) && (DrawY >= pos_y_s_q) &&
                 (col_cur < COL_END) && (row_cur < ROW_END) &&
                 (DrawX < SCR_W) && (DrawY < LOAD_Y);
      addr_c = '0;
      if (inside_c) begin
         addr_c = ADDR_W'(rbase_cur) + ADDR_W'(col_cur);
      end
   end

   // Stages 1 and 2: ROM address, then delay flags and background to meet rom_q
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         rom_addr_q <= '0;
         in1_q      <= 1'b0;
         blank1_q   <= 1'b0;
         bg_r1_q    <= '0;
         bg_g1_q    <= '0;
         bg_b1_q    <= '0;
         in2_q      <= 1'b0;
         blank2_q   <= 1'b0;
         bg_r2_q    <= '0;
         bg_g2_q    <= '0;
         bg_b2_q    <= '0;
      end else begin
         rom_addr_q <= addr_c;
         in1_q      <= inside_c;
         blank1_q   <= blank;
         bg_r1_q    <= bg_red;
         bg_g1_q    <= bg_green;
         bg_b1_q    <= bg_blue;
         in2_q      <= in1_q;
         blank2_q   <= blank1_q;
         bg_r2_q    <= bg_r1_q;
         bg_g2_q    <= bg_g1_q;
         bg_b2_q    <= bg_b1_q;
      end
   end

   // Stage 3 compositing: blanking forces black, opaque sprite texels win over background
   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      hit_d   = 1'b0;
      if (blank2_q) begin
         if (in2_q && (rom_q != CLEAR_IDX)) begin
            red_d   = pal_red;
            green_d = pal_green;
            blue_d  = pal_blue;
            hit_d   = 1'b1;
         end else begin
            red_d   = bg_r2_q;
            green_d = bg_g2_q;
            blue_d  = bg_b2_q;
         end
      end
   end

   // Output registers
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         hit_q   <= 1'b0;
      end else begin
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         hit_q   <= hit_d;
      end
   end

   assign rom_addr   = rom_addr_q;
   assign pal_index  = rom_q;
   assign red        = red_q;
   assign green      = green_q;
   assign blue       = blue_q;
   assign sprite_hit = hit_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Bench for sprite_layer_renderer on a reduced 64x40 screen with a 16x8 sprite.
// ROM texel at address a holds (a+5) mod 16; palette is a fixed function of the index.
module tb_sprite_layer_renderer;

   localparam int SW   = 64;
   localparam int SH   = 40;
   localparam int HT   = 68;
   localparam int VT   = 42;
   localparam int SPRW = 16;
   localparam int SPRH = 8;
   localparam int MAXS = 4;

   logic       vga_clk = 1'b0;
   logic       reset;
   logic [9:0] DrawX, DrawY, pos_x, pos_y;
   logic       blank, sprite_en, sprite_hit;
   logic [2:0] scale;
   logic [3:0] bg_red, bg_green, bg_blue;
   logic [6:0] rom_addr;
   logic [3:0] rom_q = 4'd0;
   logic [3:0] pal_index, pal_red, pal_green, pal_blue;
   logic [3:0] red, green, blue;

   sprite_layer_renderer #(
      .SCREEN_W(SW), .SCREEN_H(SH), .SPR_W(SPRW), .SPR_H(SPRH), .IDX_W(4), .COLOR_W(4),
      .MAX_SCALE(MAXS), .TRANSPARENT_IDX(0)
   ) dut (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .sprite_en(sprite_en),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
      .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
      .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
      .red(red), .green(green), .blue(blue), .sprite_hit(sprite_hit)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic logic [11:0] pal_of(input int i);
      logic [11:0] c;
      if (i == 5) c = 12'hF00;
      else c = {4'(i), 4'(15 - i), 4'(i * 3)};
      return c;
   endfunction

   // Synchronous ROM and combinational palette
   always @(posedge vga_clk) rom_q <= rom_addr[3:0] + 4'd5;
   always_comb {pal_red, pal_green, pal_blue} = pal_of(int'(pal_index));

   typedef struct {
      int          addr;
      bit          chk_addr;
      logic [11:0] rgb;
      bit          hit;
   } exp_t;

   typedef struct {
      int          px, py, sc;
      bit          en;
      int          x, y;
      bit          nb;
      int          addr;
      logic [11:0] rgb;
      bit          hit;
   } vec_t;

   exp_t        hist[$];
   vec_t        tbl[12];
   int          n_tests = 0, n_fail = 0;
   int          sx = 0, sy = 0;
   int          m_px = 0, m_py = 0, m_sc = 1;
   bit          m_en = 0;
   bit          force_blank = 0, rand_mode = 0, chk_en = 1;
   logic [11:0] bg_col = 12'h0A5;

   task automatic check(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp_v);
      end
   endtask

   function automatic int clamp_scale(input int s);
      if (s == 0) return 1;
      if (s > MAXS) return MAXS;
      return s;
   endfunction

   // Drive one pixel, predict it from the sprite rules, then check the pipeline outputs
   task automatic tick();
      exp_t e;
      int   dx, dy, idx;
      bit   ins, bl;
      if (rand_mode) begin
         force_blank = ($urandom_range(15) == 0);
         bg_col      = 12'($urandom);
      end
      bl = (sx < SW) && (sy < SH) && !force_blank;
      DrawX = 10'(sx);
      DrawY = 10'(sy);
      blank = bl;
      {bg_red, bg_green, bg_blue} = bg_col;
      dx  = sx - m_px;
      dy  = sy - m_py;
      ins = m_en && dx >= 0 && dx < SPRW * m_sc && dy >= 0 && dy < SPRH * m_sc;
      e.addr     = ins ? (dx / m_sc + (dy / m_sc) * SPRW) : 0;
      e.chk_addr = (sx < SW) && (sy < SH);
      idx        = (e.addr + 5) % 16;
      if (!bl) begin
         e.rgb = 12'h000; e.hit = 0;
      end else if (ins && idx != 0) begin
         e.rgb = pal_of(idx); e.hit = 1;
      end else begin
         e.rgb = bg_col; e.hit = 0;
      end
      hist.push_front(e);
      if (sx == 0 && sy == SH) begin
         m_px = int'(pos_x);
         m_py = int'(pos_y);
         m_sc = clamp_scale(int'(scale));
         m_en = sprite_en;
      end
      sx++;
      if (sx == HT) begin
         sx = 0;
         sy = (sy == VT - 1) ? 0 : sy + 1;
      end
      @(posedge vga_clk);
      #1;
      if (chk_en) begin
         if (hist[0].chk_addr) check("model.rom_addr", int'(rom_addr), hist[0].addr);
         if (hist.size() >= 3) begin
            check("model.rgb", int'({red, green, blue}), int'(hist[2].rgb));
            check("model.hit", int'(sprite_hit), int'(hist[2].hit));
         end
      end
      if (hist.size() > 3) void'(hist.pop_back());
   endtask

   task automatic run_to(input int x, input int y);
      for (int i = 0; i < HT * VT + 2 && !(sx == x && sy == y); i++) tick();
      if (!(sx == x && sy == y)) begin
         n_tests++;
         n_fail++;
         $display("FAIL run_to: scan at (%0d,%0d), required (%0d,%0d)", sx, sy, x, y);
      end
   endtask

   task automatic probe(input string nm, input int x, input int y, input bit nb,
                        input int eaddr, input logic [11:0] ergb, input bit ehit);
      run_to(x, y);
      force_blank = nb;
      tick();
      force_blank = 0;
      check({nm, ".rom_addr"}, int'(rom_addr), eaddr);
      tick();
      tick();
      check({nm, ".rgb"}, int'({red, green, blue}), int'(ergb));
      check({nm, ".hit"}, int'(sprite_hit), int'(ehit));
   endtask

   task automatic load_cfg(input int px, input int py, input int sc, input bit en);
      pos_x = 10'(px);
      pos_y = 10'(py);
      scale = 3'(sc);
      sprite_en = en;
      run_to(0, SH);
      tick();
   endtask

   initial begin
      int  hits;
      bit  cfg_ok;
      reset = 1'b1;
      pos_x = '0; pos_y = '0; scale = 3'd1; sprite_en = 1'b0;
      DrawX = '0; DrawY = '0; blank = 1'b0;
      {bg_red, bg_green, bg_blue} = 12'h0A5;

      //           px  py sc en   x   y nb addr  rgb      hit
      tbl[0]  = '{ 0,  0, 1, 1,   0,  0, 0,   0, 12'hF00, 1};
      tbl[1]  = '{ 0,  0, 1, 1,  11,  0, 0,  11, 12'h0A5, 0};
      tbl[2]  = '{ 0,  0, 1, 1,  16,  0, 0,   0, 12'h0A5, 0};
      tbl[3]  = '{ 0,  0, 1, 1,   3,  2, 0,  35, 12'h878, 1};
      tbl[4]  = '{ 0,  0, 1, 1,   0,  0, 1,   0, 12'h000, 0};
      tbl[5]  = '{10,  5, 3, 1,  33, 17, 0,  71, 12'hC34, 1};
      tbl[6]  = '{10,  5, 3, 1,  58,  5, 0,   0, 12'h0A5, 0};
      tbl[7]  = '{20, 10, 0, 1,  21, 11, 0,  17, 12'h692, 1};
      tbl[8]  = '{ 0,  0, 7, 1,   9,  5, 0,  18, 12'h785, 1};
      tbl[9]  = '{ 0,  0, 7, 1,  63, 31, 0, 127, 12'h4BC, 1};
      tbl[10] = '{50, 35, 1, 1,  63, 39, 0,  77, 12'h2D6, 1};
      tbl[11] = '{ 0,  0, 1, 0,   0,  0, 0,   0, 12'h0A5, 0};

      // Reset state
      repeat (2) @(posedge vga_clk);
      #1;
      check("reset.red", int'(red), 0);
      check("reset.green", int'(green), 0);
      check("reset.blue", int'(blue), 0);
      check("reset.hit", int'(sprite_hit), 0);
      check("reset.rom_addr", int'(rom_addr), 0);
      reset = 1'b0;

      // Directed vectors; a new configuration takes one load point to become visible
      cfg_ok = 0;
      for (int i = 0; i < 12; i++) begin
         if (!cfg_ok || i == 0 || tbl[i].px != tbl[i-1].px || tbl[i].py != tbl[i-1].py ||
             tbl[i].sc != tbl[i-1].sc || tbl[i].en != tbl[i-1].en) begin
            load_cfg(tbl[i].px, tbl[i].py, tbl[i].sc, tbl[i].en);
            cfg_ok = 1;
         end
         probe($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].nb, tbl[i].addr,
               tbl[i].rgb, tbl[i].hit);
      end

      // Mid-frame position change is ignored until the next load point
      load_cfg(0, 0, 4, 1);
      run_to(0, 20);
      pos_x = 10'd30;
      probe("midframe.old_pos", 0, 24, 0, 96, 12'hF00, 1);
      run_to(0, SH);
      tick();
      probe("nextframe.left", 0, 0, 0, 0, 12'h0A5, 0);
      probe("nextframe.start", 30, 0, 0, 0, 12'hF00, 1);

      // Reset mid-frame: immediate zeros, then background only until the next load
      pos_x = 10'd0;
      scale = 3'd1;
      run_to(0, 30);
      #2;
      reset = 1'b1;
      #1;
      check("midreset.red", int'(red), 0);
      check("midreset.green", int'(green), 0);
      check("midreset.blue", int'(blue), 0);
      check("midreset.hit", int'(sprite_hit), 0);
      check("midreset.rom_addr", int'(rom_addr), 0);
      chk_en = 0;
      tick();
      tick();
      reset = 1'b0;
      hist.delete();
      m_px = 0; m_py = 0; m_sc = 1; m_en = 0;
      chk_en = 1;
      hits = 0;
      for (int i = 0; i < HT * VT && !(sx == 0 && sy == SH); i++) begin
         tick();
         hits += int'(sprite_hit);
      end
      check("after_reset.hits", hits, 0);
      tick();
      probe("after_reset.reload", 0, 0, 0, 0, 12'hF00, 1);

      // Randomised frames against the reference model, with mid-frame setting changes
      rand_mode = 1;
      for (int f = 0; f < 7; f++) begin
         run_to(0, int'($urandom_range(5, 35)));
         pos_x     = 10'($urandom_range(0, 70));
         pos_y     = 10'($urandom_range(0, 45));
         scale     = 3'($urandom_range(0, 7));
         sprite_en = ($urandom_range(0, 7) != 0);
         run_to(0, SH);
         tick();
      end
      rand_mode = 0;
      force_blank = 0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
